// File: rtl/bth_div_gen.sv
// bth_div_gen: sequential signed integer divider (restoring shift-subtract).
//
// Divides two WIDTH-bit two's-complement operands. Each division takes
// WIDTH iteration cycles on the operand magnitudes plus one sign-fixup
// cycle. A start/busy/done handshake matches the companion Booth multiplier.
//
// Ports:
//   clk    in   rising-edge clock
//   rst    in   asynchronous active-low reset
//   start  in   request, sampled only when idle
//   inp_n  in   dividend (WIDTH, two's complement)
//   inp_d  in   divisor  (WIDTH, two's complement)
//   quot   out  quotient  (truncated toward zero)
//   rem    out  remainder (sign of the dividend)
//   busy   out  high while a division is in progress
//   done   out  one-cycle pulse when quot/rem/dz update
//   dz     out  divide-by-zero flag for the last result
module bth_div_gen #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] inp_n,
    input  logic [WIDTH-1:0] inp_d,
    output logic [WIDTH-1:0] quot,
    output logic [WIDTH-1:0] rem,
    output logic             busy,
    output logic             done,
    output logic             dz
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_q;       // dividend magnitude, shifts into quotient
    logic [WIDTH-1:0] r_m;       // divisor magnitude
    logic [WIDTH-1:0] r_a;       // partial remainder
    logic [WIDTH-1:0] r_n_raw;   // raw dividend, returned as rem on /0
    logic [CW-1:0]    r_cnt;
    logic             r_sn;
    logic             r_sd;
    logic             r_zero;

    logic [WIDTH-1:0] w_n_abs;
    logic [WIDTH-1:0] w_d_abs;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_t;

    // Unsigned negation: the most-negative value maps to 2^(WIDTH-1).
    assign w_n_abs = inp_n[WIDTH-1] ? -inp_n : inp_n;
    assign w_d_abs = inp_d[WIDTH-1] ? -inp_d : inp_d;

    // The partial remainder always stays below m <= 2^(WIDTH-1), so its
    // (WIDTH+1)-th bit is always zero and only WIDTH bits are stored.
    assign w_shift = {r_a, r_q[WIDTH-1]};
    assign w_t     = w_shift - {1'b0, r_m};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_q     <= '0;
            r_m     <= '0;
            r_a     <= '0;
            r_n_raw <= '0;
            r_cnt   <= '0;
            r_sn    <= 1'b0;
            r_sd    <= 1'b0;
            r_zero  <= 1'b0;
            quot    <= '0;
            rem     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            dz      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_q     <= w_n_abs;
                        r_m     <= w_d_abs;
                        r_sn    <= inp_n[WIDTH-1];
                        r_sd    <= inp_d[WIDTH-1];
                        r_zero  <= (inp_d == '0);
                        r_n_raw <= inp_n;
                        r_a     <= '0;
                        r_cnt   <= CW'(WIDTH);
                        busy    <= 1'b1;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    // Non-negative trial difference: keep it, quotient bit 1.
                    if (!w_t[WIDTH]) begin
                        r_a <= w_t[WIDTH-1:0];
                        r_q <= {r_q[WIDTH-2:0], 1'b1};
                    end else begin
                        r_a <= w_shift[WIDTH-1:0];
                        r_q <= {r_q[WIDTH-2:0], 1'b0};
                    end
                    r_cnt <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) begin
                        r_state <= FIX;
                    end
                end
                FIX: begin
                    if (r_zero) begin
                        quot <= '1;
                        rem  <= r_n_raw;
                    end else begin
                        quot <= (r_sn ^ r_sd) ? -r_q : r_q;
                        rem  <= r_sn ? -r_a : r_a;
                    end
                    dz      <= r_zero;
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bth_div_gen.sv
module tb_bth_div_gen;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic       s4;
    logic [3:0] n4, d4, q4, r4;
    logic       b4, dn4, z4;
    logic       s8;
    logic [7:0] n8, d8, q8, r8;
    logic       b8, dn8, z8;

    bth_div_gen #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(s4), .inp_n(n4), .inp_d(d4),
        .quot(q4), .rem(r4), .busy(b4), .done(dn4), .dz(z4)
    );

    bth_div_gen #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(s8), .inp_n(n8), .inp_d(d8),
        .quot(q8), .rem(r8), .busy(b8), .done(dn8), .dz(z8)
    );

    int total = 0;
    int bad   = 0;
    bit mon_en = 1'b0;
    logic p4 = 1'b0, p8 = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Reference: Verilog signed / and % on full-width ints, truncated to w bits.
    task automatic model(input int w, input int n, input int d,
                         output int q, output int r, output int z);
        int mask;
        mask = (1 << w) - 1;
        if (d == 0) begin
            q = mask; r = n & mask; z = 1;
        end else begin
            q = (n / d) & mask; r = (n % d) & mask; z = 0;
        end
    endtask

    // Handshake invariants, checked every cycle on both instances.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("busy_and_done4", {31'd0, b4 & dn4}, 32'd0);
            chk("done_twice4",    {31'd0, p4 & dn4}, 32'd0);
            chk("busy_and_done8", {31'd0, b8 & dn8}, 32'd0);
            chk("done_twice8",    {31'd0, p8 & dn8}, 32'd0);
            p4 = dn4;
            p8 = dn8;
        end
    end

    // Call #1 after a rising edge with the DUT idle; returns #1 after the
    // edge that raises done, with lat = edges counted after the accept edge.
    task automatic do4(input logic [3:0] n, input logic [3:0] d, output int lat);
        s4 = 1'b1; n4 = n; d4 = d;
        @(posedge clk); #1;
        s4 = 1'b0; lat = 0;
        while (dn4 !== 1'b1 && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
    endtask

    task automatic do8(input logic [7:0] n, input logic [7:0] d, output int lat);
        s8 = 1'b1; n8 = n; d8 = d;
        @(posedge clk); #1;
        s8 = 1'b0; lat = 0;
        while (dn8 !== 1'b1 && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
    endtask

    typedef struct {
        logic [3:0] n, d, q, r;
        logic       z;
    } vec_t;

    vec_t tbl[10];

    initial begin
        int lat, eq, er, ez, cyc, last, cnt;
        logic [3:0] rn4, rd4;
        logic [7:0] rn8, rd8;

        tbl[0] = '{4'd7,    4'd2,    4'b0011, 4'b0001, 1'b0};
        tbl[1] = '{4'b1001, 4'd2,    4'b1101, 4'b1111, 1'b0};
        tbl[2] = '{4'd7,    4'b1110, 4'b1101, 4'b0001, 1'b0};
        tbl[3] = '{4'b1001, 4'b1110, 4'b0011, 4'b1111, 1'b0};
        tbl[4] = '{4'b1000, 4'b1111, 4'b1000, 4'b0000, 1'b0};
        tbl[5] = '{4'b1000, 4'd1,    4'b1000, 4'b0000, 1'b0};
        tbl[6] = '{4'd3,    4'd7,    4'b0000, 4'b0011, 1'b0};
        tbl[7] = '{4'd0,    4'd5,    4'b0000, 4'b0000, 1'b0};
        tbl[8] = '{4'd5,    4'd0,    4'b1111, 4'b0101, 1'b1};
        tbl[9] = '{4'd6,    4'd3,    4'b0010, 4'b0000, 1'b0};

        s4 = 1'b0; n4 = '0; d4 = '0;
        s8 = 1'b0; n8 = '0; d8 = '0;

        // Reset state.
        #12;
        chk("rst_quot", {28'd0, q4}, 32'd0);
        chk("rst_rem",  {28'd0, r4}, 32'd0);
        chk("rst_dz",   {31'd0, z4}, 32'd0);
        chk("rst_busy", {31'd0, b4}, 32'd0);
        chk("rst_done", {31'd0, dn4}, 32'd0);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        mon_en = 1'b1;

        // Directed table, issued back-to-back in each done cycle.
        foreach (tbl[i]) begin
            do4(tbl[i].n, tbl[i].d, lat);
            chk($sformatf("tbl%0d_lat", i),  lat, 32'd5);
            chk($sformatf("tbl%0d_quot", i), {28'd0, q4}, {28'd0, tbl[i].q});
            chk($sformatf("tbl%0d_rem", i),  {28'd0, r4}, {28'd0, tbl[i].r});
            chk($sformatf("tbl%0d_dz", i),   {31'd0, z4}, {31'd0, tbl[i].z});
        end

        // start held high: one result every 6 clocks.
        s4 = 1'b1; n4 = 4'd7; d4 = 4'd2;
        cyc = 0; last = -1; cnt = 0;
        while (cnt < 3 && cyc < 40) begin
            @(posedge clk); #1; cyc++;
            if (dn4 === 1'b1) begin
                if (last >= 0) chk("held_period", cyc - last, 32'd6);
                chk("held_quot", {28'd0, q4}, 32'd3);
                last = cyc; cnt++;
            end
        end
        s4 = 1'b0;
        chk("held_count", cnt, 32'd3);

        // start pulsed during RUN with other operands is ignored.
        s4 = 1'b1; n4 = 4'd7; d4 = 4'd2;
        @(posedge clk); #1; s4 = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        s4 = 1'b1; n4 = 4'd5; d4 = 4'd1;
        @(posedge clk); #1; s4 = 1'b0;
        lat = 3;
        while (dn4 !== 1'b1 && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        chk("ign_lat",  lat, 32'd5);
        chk("ign_quot", {28'd0, q4}, 32'd3);
        chk("ign_rem",  {28'd0, r4}, 32'd1);

        // Reset mid-RUN: outputs cleared at once, no done pulse.
        @(posedge clk); #1;
        s4 = 1'b1; n4 = 4'd7; d4 = 4'd2;
        @(posedge clk); #1; s4 = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("mrst_quot", {28'd0, q4}, 32'd0);
        chk("mrst_rem",  {28'd0, r4}, 32'd0);
        chk("mrst_busy", {31'd0, b4}, 32'd0);
        chk("mrst_done", {31'd0, dn4}, 32'd0);
        cnt = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (dn4 !== 1'b0) cnt++;
        end
        chk("mrst_nodone", cnt, 32'd0);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        do4(4'd6, 4'd3, lat);
        chk("post_rst_lat",  lat, 32'd5);
        chk("post_rst_quot", {28'd0, q4}, 32'd2);
        chk("post_rst_rem",  {28'd0, r4}, 32'd0);

        // Random WIDTH=4 against the arithmetic model.
        for (int k = 0; k < 1000; k++) begin
            rn4 = 4'($urandom);
            rd4 = 4'($urandom);
            do4(rn4, rd4, lat);
            model(4, int'($signed(rn4)), int'($signed(rd4)), eq, er, ez);
            chk("r4_lat",  lat, 32'd5);
            chk("r4_quot", {28'd0, q4}, eq);
            chk("r4_rem",  {28'd0, r4}, er);
            chk("r4_dz",   {31'd0, z4}, ez);
        end

        // Random WIDTH=8, with extra zero divisors.
        for (int k = 0; k < 1000; k++) begin
            rn8 = 8'($urandom);
            rd8 = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom);
            do8(rn8, rd8, lat);
            model(8, int'($signed(rn8)), int'($signed(rd8)), eq, er, ez);
            chk("r8_lat",  lat, 32'd9);
            chk("r8_quot", {24'd0, q8}, eq);
            chk("r8_rem",  {24'd0, r8}, er);
            chk("r8_dz",   {31'd0, z8}, ez);
        end

        @(posedge clk); #1;
        mon_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bth_div_gen.md
# bth_div_gen

Sequential signed integer divider, the inverse companion of the Booth multiplier in the same arithmetic datapath. It takes two WIDTH-bit two's-complement operands and produces quotient and remainder. It uses a shift-subtract (restoring) iteration on operand magnitudes, one quotient bit per clock, followed by a sign-fixup cycle. It uses a start/busy/done handshake so a controller can sequence it the same way it sequences the multiplier.

## Interface
- WIDTH, 4, operand/result width in bits (≥2)
- clk  input  1  clock, rising edge
- rst  input  1  reset, asynchronous, active-low
- start  input  1  request; sampled only in IDLE
- inp_n  input  WIDTH  dividend, two's complement
- inp_d  input  WIDTH  divisor, two's complement
- quot  output  WIDTH  quotient, two's complement
- rem  output  WIDTH  remainder, two's complement
- busy  output  1  high while a division is in progress
- done  output  1  one-cycle pulse: quot/rem/dz just updated
- dz  output  1  divide-by-zero flag for the last result

## Operation
- States: IDLE, RUN, FIX.
- IDLE: on start=1:
  - latch |inp_n| into q (WIDTH bits, unsigned) and |inp_d| into m (WIDTH bits, unsigned).
  - latch sn=inp_n[MSB], sd=inp_d[MSB], zero flag (inp_d==0), and the raw inp_n.
  - clear partial remainder a (WIDTH+1 bits); set count=WIDTH; go to RUN.
- |x| is the unsigned WIDTH-bit negation, so the most-negative value maps to 2^(WIDTH-1) with no overflow.
- RUN, each cycle:
  - t = {a[WIDTH-1:0], q[MSB]} − {1'b0, m}, computed WIDTH+1 bits wide.
  - If t is non-negative: a←t and q←{q[WIDTH-2:0],1}.
  - Otherwise: a←{a[WIDTH-1:0], q[MSB]} and q←{q[WIDTH-2:0],0}.
  - count decrements; when it reaches 0 after the WIDTH-th iteration, go to FIX.
- FIX (one cycle), then return to IDLE:
  - quot ← (sn^sd) ? −q : q.
  - rem ← sn ? −a[WIDTH-1:0] : a[WIDTH-1:0].
  - dz ← zero flag.
  - If the zero flag is set, override: quot ← all ones, rem ← raw latched dividend.
- Semantics: truncation toward zero; the remainder carries the dividend's sign, matching Verilog signed / and %.
- Overflow: most-negative ÷ −1 wraps, giving quot = most-negative and rem = 0. There is no flag for this case.
- start while busy (RUN/FIX) is ignored. Inputs are not sampled after the IDLE accept cycle.
- quot, rem, and dz hold their values until the next FIX; they are not cleared by a new start.

## Timing
- Reset (rst=0, asynchronous, any state):
  - state=IDLE; quot=0, rem=0, dz=0, busy=0, done=0.
  - All internal registers cleared.
  - An in-flight division is abandoned with no done pulse.
- Reset release: the first start can be accepted on the first rising edge with rst=1.
- Edge E0: start is sampled in IDLE. busy goes high after E0.
- Edges E1..E_WIDTH: iterations.
- Edge E_WIDTH+1: FIX registers the results.
  - done=1 and busy=0 during the cycle after E_WIDTH+1.
  - done falls after the following edge.
- Latency is WIDTH+1 clocks from the start edge to visible results, fixed and independent of operand values including divisor zero.
- start=1 during the done cycle is accepted (state is IDLE), giving back-to-back throughput of one result per WIDTH+2 clocks.
- done is never high for two consecutive cycles.
- busy and done are never high simultaneously.

## Test plan
- WIDTH=4, 7÷2 -> after 5 clocks: done=1, quot=4'b0011, rem=4'b0001, dz=0.
- Signed quadrants (WIDTH=4):
  - −7÷2 -> quot=4'b1101, rem=4'b1111.
  - 7÷−2 -> quot=4'b1101, rem=4'b0001.
  - −7÷−2 -> quot=4'b0011, rem=4'b1111.
- Boundaries (WIDTH=4):
  - −8÷−1 -> quot=4'b1000, rem=0.
  - −8÷1 -> quot=4'b1000, rem=0.
  - 3÷7 -> quot=0, rem=4'b0011.
  - 0÷5 -> quot=0, rem=0.
- 5÷0 -> done after 5 clocks, dz=1, quot=4'b1111, rem=4'b0101. The next valid division clears dz.
- Handshake:
  - Pulse start at cycle 2 of RUN with different operands -> ignored; the result matches the first operands.
  - start held high continuously -> results appear every 6 clocks.
  - busy and done are never simultaneously high.
- Drive rst=0 mid-RUN -> outputs are 0 immediately, with no done pulse. After release, 6÷3 gives quot=2, rem=0.
- Randomised: 1000 random operand pairs at WIDTH=4 and WIDTH=8 compared against the signed /, % model, with divisor 0 checked against the dz rule.
